// File: rtl/layer_cfg_loader.sv
// Layer configuration loader: shadow register file, validation, and
// start/enable/layer_done handshake with a post-layer flush window.
module layer_cfg_loader #(
  parameter int TENSOR_W     = 8,
  parameter int KERNEL_W     = 4,
  parameter int CHANNELS_W   = 8,
  parameter int STRIDE_W     = 4,
  parameter int KNUMS_W      = 8,
  parameter int ARM_TIMEOUT  = 64,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [2:0]            cfg_addr,
  input  logic [15:0]           cfg_data,
  input  logic                  enable,
  input  logic                  layer_done,
  input  logic                  abort,
  output logic [TENSOR_W-1:0]   tensor_size,
  output logic [KERNEL_W-1:0]   kernel_size,
  output logic [CHANNELS_W-1:0] channels,
  output logic [STRIDE_W-1:0]   stride,
  output logic [KNUMS_W-1:0]    kernel_nums,
  output logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [5:0]            err_code
);

  localparam int AW = $clog2(ARM_TIMEOUT + 1);
  localparam logic [AW-1:0] ARM_LAST = AW'(ARM_TIMEOUT - 1);
  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GO,
    S_CHECK,
    S_ARM,
    S_RUN,
    S_FLUSH,
    S_ERR
  } state_t;

  state_t state;

  logic [TENSOR_W-1:0]   sh_tensor;
  logic [KERNEL_W-1:0]   sh_kernel;
  logic [CHANNELS_W-1:0] sh_channels;
  logic [STRIDE_W-1:0]   sh_stride;
  logic [KNUMS_W-1:0]    sh_knums;

  logic [AW-1:0] arm_cnt;
  logic [3:0]    flush_cnt;
  logic [5:0]    fails;
  logic          wr;
  logic          unused_data;

  assign cfg_ready = (state == S_IDLE) || (state == S_ERR);
  assign wr = cfg_valid && cfg_ready;
  assign unused_data = ^cfg_data;

  always_comb begin
    fails = '0;
    fails[0] = (sh_stride == '0);
    fails[1] = (sh_kernel == '0);
    fails[2] = (32'(sh_kernel) > 32'(sh_tensor));
    fails[3] = (sh_channels == '0);
    fails[4] = (sh_knums == '0);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      sh_tensor   <= '0;
      sh_kernel   <= '0;
      sh_channels <= '0;
      sh_stride   <= '0;
      sh_knums    <= '0;
      tensor_size <= '0;
      kernel_size <= '0;
      channels    <= '0;
      stride      <= '0;
      kernel_nums <= '0;
      start       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      err_code    <= '0;
      arm_cnt     <= '0;
      flush_cnt   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (wr) begin
            unique case (1'b1)
              (cfg_addr == 3'd0): sh_tensor   <= cfg_data[TENSOR_W-1:0];
              (cfg_addr == 3'd1): sh_kernel   <= cfg_data[KERNEL_W-1:0];
              (cfg_addr == 3'd2): sh_channels <= cfg_data[CHANNELS_W-1:0];
              (cfg_addr == 3'd3): sh_stride   <= cfg_data[STRIDE_W-1:0];
              (cfg_addr == 3'd4): sh_knums    <= cfg_data[KNUMS_W-1:0];
              (cfg_addr == 3'd5): begin
                state <= S_GO;
                busy  <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        // staging cycle so CHECK sees a settled shadow file
        S_GO: state <= S_CHECK;
        S_CHECK: begin
          if (fails != '0) begin
            state    <= S_ERR;
            err      <= 1'b1;
            err_code <= fails;
            busy     <= 1'b0;
          end else begin
            tensor_size <= sh_tensor;
            kernel_size <= sh_kernel;
            channels    <= sh_channels;
            stride      <= sh_stride;
            kernel_nums <= sh_knums;
            start       <= 1'b1;
            arm_cnt     <= '0;
            state       <= S_ARM;
          end
        end
        S_ARM: begin
          if (abort) begin
            state     <= S_FLUSH;
            start     <= 1'b0;
            flush_cnt <= '0;
          end else if (enable) begin
            state <= S_RUN;
          end else if (arm_cnt == ARM_LAST) begin
            state    <= S_ERR;
            start    <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b1;
            err_code <= 6'b100000;
          end else begin
            arm_cnt <= arm_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (layer_done || abort) begin
            state     <= S_FLUSH;
            start     <= 1'b0;
            done      <= layer_done;
            flush_cnt <= '0;
          end
        end
        S_FLUSH: begin
          if (flush_cnt == FLUSH_LAST) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        S_ERR: begin
          if (wr && cfg_addr == 3'd7) begin
            state    <= S_IDLE;
            err      <= 1'b0;
            err_code <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_cfg_loader.sv
// Directed plus randomized bench for layer_cfg_loader against a
// rule-level reference model of configuration and layer sequencing.
module tb_layer_cfg_loader;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [2:0]  cfg_addr = '0;
  logic [15:0] cfg_data = '0;
  logic        enable = 1'b0;
  logic        layer_done = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  tensor_size;
  logic [3:0]  kernel_size;
  logic [7:0]  channels;
  logic [3:0]  stride;
  logic [7:0]  kernel_nums;
  logic        start;
  logic        busy;
  logic        done;
  logic        err;
  logic [5:0]  err_code;

  layer_cfg_loader dut (
    .clk        (clk),
    .rstn       (rstn),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .enable     (enable),
    .layer_done (layer_done),
    .abort      (abort),
    .tensor_size(tensor_size),
    .kernel_size(kernel_size),
    .channels   (channels),
    .stride     (stride),
    .kernel_nums(kernel_nums),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int widths[5] = '{8, 4, 8, 4, 8};
  int m_sh[5] = '{0, 0, 0, 0, 0};
  int m_act[5] = '{0, 0, 0, 0, 0};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] rules(input int t, input int k,
                                       input int c, input int s,
                                       input int n);
    logic [5:0] code;
    code = '0;
    if (s == 0) code = code | 6'd1;
    if (k == 0) code = code | 6'd2;
    if (k > t) code = code | 6'd4;
    if (c == 0) code = code | 6'd8;
    if (n == 0) code = code | 6'd16;
    return code;
  endfunction

  function automatic logic [31:0] pack_act();
    return 32'((m_act[0] << 24) + (m_act[1] << 20) + (m_act[2] << 12)
             + (m_act[3] << 8) + m_act[4]);
  endfunction

  function automatic logic [31:0] act_obs();
    return {tensor_size, kernel_size, channels, stride, kernel_nums};
  endfunction

  task automatic wr(input int a, input int d, input bit upd);
    cfg_valid = 1'b1;
    cfg_addr = 3'(a);
    cfg_data = 16'(d);
    @(negedge clk);
    cfg_valid = 1'b0;
    if (upd && a < 5) m_sh[a] = (d & 16'hffff) % (1 << widths[a]);
  endtask

  task automatic go_check(output bit ok);
    logic [5:0] code;
    code = rules(m_sh[0], m_sh[1], m_sh[2], m_sh[3], m_sh[4]);
    wr(5, int'($urandom), 0);
    chk("go_ready", 32'(cfg_ready), 0);
    chk("go_start_e0", 32'(start), 0);
    @(negedge clk);
    chk("go_start_e1", 32'(start), 0);
    @(negedge clk);
    if (code != 0) begin
      chk("val_err", 32'(err), 1);
      chk("val_code", 32'(err_code), 32'(code));
      chk("val_start", 32'(start), 0);
      chk("val_busy", 32'(busy), 0);
      chk("val_ready", 32'(cfg_ready), 1);
      chk("val_active", act_obs(), pack_act());
      ok = 0;
    end else begin
      m_act = m_sh;
      chk("arm_start", 32'(start), 1);
      chk("arm_busy", 32'(busy), 1);
      chk("arm_err", 32'(err), 0);
      chk("arm_active", act_obs(), pack_act());
      ok = 1;
    end
  endtask

  task automatic clear_err();
    wr(7, int'($urandom), 0);
    chk("clr_err", 32'(err), 0);
    chk("clr_code", 32'(err_code), 0);
    chk("clr_ready", 32'(cfg_ready), 1);
    chk("clr_busy", 32'(busy), 0);
  endtask

  task automatic arm_to_run(input int d);
    repeat (d) @(negedge clk);
    chk("arm_hold", 32'(start), 1);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    chk("run_start", 32'(start), 1);
    chk("run_busy", 32'(busy), 1);
    repeat (3) @(negedge clk);
    chk("run_en_drop", 32'(start), 1);
    chk("run_no_done", 32'(done), 0);
  endtask

  // kind 0: layer_done, 1: abort, 2: both together
  task automatic finish(input int kind);
    layer_done = (kind != 1);
    abort = (kind != 0);
    @(negedge clk);
    layer_done = 1'b0;
    abort = 1'b0;
    chk("fl_done", 32'(done), 32'(kind != 1));
    chk("fl_start", 32'(start), 0);
    chk("fl_busy", 32'(busy), 1);
    chk("fl_ready", 32'(cfg_ready), 0);
    @(negedge clk);
    chk("fl_done_end", 32'(done), 0);
    chk("fl_busy2", 32'(busy), 1);
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_ready", 32'(cfg_ready), 1);
    chk("idle_start", 32'(start), 0);
    chk("idle_active", act_obs(), pack_act());
  endtask

  initial begin
    bit ok;
    @(negedge clk);
    @(negedge clk);
    chk("rst_start", 32'(start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'({err, err_code}), 0);
    chk("rst_ready", 32'(cfg_ready), 1);
    chk("rst_active", act_obs(), 0);
    rstn = 1'b1;
    @(negedge clk);

    enable = 1'b1;
    layer_done = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    layer_done = 1'b0;
    abort = 1'b0;
    chk("idle_ign", 32'({busy, start, done, err}), 0);

    // validation failure: kernel 9 > tensor 8, stride 0
    wr(1, 9, 1);
    wr(0, 8, 1);
    wr(2, 2, 1);
    wr(4, 4, 1);
    wr(3, 0, 1);
    go_check(ok);
    chk("val_code_fix", 32'(err_code), 32'h05);
    chk("val_act_zero", act_obs(), 0);
    wr(3, 1, 0);
    chk("err_ign_wr", 32'(err), 1);
    clear_err();
    go_check(ok);
    clear_err();

    // normal layer with shadow isolation during RUN
    wr(1, 3, 1);
    wr(3, 1, 1);
    go_check(ok);
    chk("norm_act", act_obs(), 32'h08302104);
    arm_to_run(2);
    cfg_valid = 1'b1;
    cfg_addr = 3'd0;
    cfg_data = 16'd16;
    #1;
    chk("run_ready", 32'(cfg_ready), 0);
    @(negedge clk);
    cfg_valid = 1'b0;
    repeat (10) @(negedge clk);
    finish(0);
    wr(0, 16, 1);
    chk("shadow_iso", 32'(tensor_size), 8);
    go_check(ok);
    chk("shadow_new", 32'(tensor_size), 16);
    arm_to_run(0);
    finish(2);

    // ARM timeout and enable-in-expiry-cycle
    go_check(ok);
    repeat (63) @(negedge clk);
    chk("to_pre", 32'({start, err}), 32'h2);
    @(negedge clk);
    chk("to_err", 32'(err), 1);
    chk("to_code", 32'(err_code), 32'h20);
    chk("to_start", 32'(start), 0);
    chk("to_busy", 32'(busy), 0);
    clear_err();
    go_check(ok);
    repeat (63) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    chk("to_en_err", 32'(err), 0);
    chk("to_en_run", 32'(start), 1);
    finish(0);

    // abort in RUN, abort in ARM
    go_check(ok);
    arm_to_run(1);
    finish(1);
    go_check(ok);
    finish(1);

    for (int it = 0; it < 25; it++) begin
      int lim[5] = '{12, 15, 3, 3, 3};
      for (int f = 0; f < 5; f++) begin
        if ($urandom_range(0, 1) == 1) begin
          int v;
          v = int'($urandom_range(0, lim[f]));
          v = v | (int'($urandom_range(0, 3)) << widths[f]);
          wr(f, v, 1);
        end
      end
      go_check(ok);
      if (ok) begin
        arm_to_run(int'($urandom_range(0, 6)));
        repeat ($urandom_range(0, 4)) @(negedge clk);
        finish(int'($urandom_range(0, 2)));
      end else begin
        clear_err();
      end
    end

    // async reset in the middle of RUN
    for (int f = 0; f < 5; f++) wr(f, 5, 1);
    go_check(ok);
    arm_to_run(0);
    rstn = 1'b0;
    #1;
    chk("mrst_start", 32'(start), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_active", act_obs(), 0);
    chk("mrst_ready", 32'(cfg_ready), 1);
    @(negedge clk);
    rstn = 1'b1;
    m_sh = '{0, 0, 0, 0, 0};
    m_act = '{0, 0, 0, 0, 0};
    @(negedge clk);
    go_check(ok);
    chk("mrst_code", 32'(err_code), 32'h1b);
    clear_err();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
